// File: rtl/dected_correct_stage.sv
// ---------------------------------------------------------------------------
// dected_correct_stage
//   Correction stage that sits directly after the DECTED syndrome decoder.
//   Each incoming word is classified as clean, single-error corrected or
//   uncorrectable. A corrected word has its located bit flipped. The result
//   passes through an input register (S1) and then a 2-entry output FIFO that
//   sits behind a valid/ready handshake. The stage also keeps saturating
//   counters of corrected and uncorrectable words, and a sticky log of the
//   first uncorrectable word.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             upstream handshake
//   in_data/in_synd/in_loc/in_tag raw word, syndrome, location vector, tag
//   out_valid/out_ready           downstream handshake
//   out_data/out_tag/out_stat     corrected word, its tag, classification
//                                 (00 clean, 01 corrected, 10 uncorrectable)
//   cnt_sgl/cnt_dbl, clr_cnt      saturating error counters and their clear
//   log_vld/log_tag/log_synd      sticky first-uncorrectable log
//   log_clr                       re-arms the log
// ---------------------------------------------------------------------------
module dected_correct_stage #(
  parameter int DATA_W = 32,
  parameter int SYND_W = 7,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SYND_W-1:0] in_synd,
  input  logic [DATA_W-1:0] in_loc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        out_stat,
  output logic [CNT_W-1:0]  cnt_sgl,
  output logic [CNT_W-1:0]  cnt_dbl,
  input  logic              clr_cnt,
  output logic              log_vld,
  output logic [TAG_W-1:0]  log_tag,
  output logic [SYND_W-1:0] log_synd,
  input  logic              log_clr
);

  typedef enum logic [1:0] {
    STAT_CLEAN  = 2'b00,
    STAT_CORR   = 2'b01,
    STAT_UNCORR = 2'b10
  } stat_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    stat_e             stat;
  } word_t;

  localparam logic [DATA_W-1:0] LOC_ONE = DATA_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  word_t             in_word;
  logic              accept, push, pop;

  logic              s1_vld_q, s1_vld_d;
  word_t             s1_word_q, s1_word_d;
  word_t             mem_q [2];
  word_t             mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]  cnt_sgl_q, cnt_sgl_d;
  logic [CNT_W-1:0]  cnt_dbl_q, cnt_dbl_d;
  logic              log_vld_q, log_vld_d;
  logic [TAG_W-1:0]  log_tag_q, log_tag_d;
  logic [SYND_W-1:0] log_synd_q, log_synd_d;

  // Classification. x & (x-1) == 0 with x != 0 is the one-hot test.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_word.data = in_data;
    in_word.tag  = in_tag;
    in_word.stat = STAT_CLEAN;
    if (in_synd != '0) begin
      if ((in_loc != '0) && ((in_loc & (in_loc - LOC_ONE)) == '0)) begin
        in_word.stat = STAT_CORR;
        in_word.data = in_data ^ in_loc;
      end else begin
        in_word.stat = STAT_UNCORR;
      end
    end
  end

  // in_ready depends on registers only: accept only while at most one word is
  // held in S1+FIFO, so the new word always has somewhere to go even if the
  // downstream stalls. This costs throughput but breaks any out_ready path.
  assign in_ready  = !((fifo_cnt_q == 2'd2) || ((fifo_cnt_q == 2'd1) && s1_vld_q));
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push      = s1_vld_q && ((fifo_cnt_q != 2'd2) || pop);

  assign out_data  = mem_q[rd_ptr_q].data;
  assign out_tag   = mem_q[rd_ptr_q].tag;
  assign out_stat  = mem_q[rd_ptr_q].stat;
  assign cnt_sgl   = cnt_sgl_q;
  assign cnt_dbl   = cnt_dbl_q;
  assign log_vld   = log_vld_q;
  assign log_tag   = log_tag_q;
  assign log_synd  = log_synd_q;

  always_comb begin
    // S1: a word accepted while S1 is full is only possible when the FIFO
    // is empty, so S1 always drains in the same edge.
    s1_vld_d  = s1_vld_q;
    s1_word_d = s1_word_q;
    if (accept) begin
      s1_vld_d  = 1'b1;
      s1_word_d = in_word;
    end else if (push) begin
      s1_vld_d  = 1'b0;
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s1_word_q;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // Counters: clear wins over a same-cycle event; saturate at all-ones.
    cnt_sgl_d = cnt_sgl_q;
    cnt_dbl_d = cnt_dbl_q;
    if (clr_cnt) begin
      cnt_sgl_d = '0;
      cnt_dbl_d = '0;
    end else if (accept) begin
      if ((in_word.stat == STAT_CORR) && (cnt_sgl_q != CNT_MAX)) cnt_sgl_d = cnt_sgl_q + CNT_ONE;
      if ((in_word.stat == STAT_UNCORR) && (cnt_dbl_q != CNT_MAX)) cnt_dbl_d = cnt_dbl_q + CNT_ONE;
    end

    // Log: a new event in the same cycle as log_clr is captured.
    log_vld_d  = log_vld_q;
    log_tag_d  = log_tag_q;
    log_synd_d = log_synd_q;
    if (accept && (in_word.stat == STAT_UNCORR) && (!log_vld_q || log_clr)) begin
      log_vld_d  = 1'b1;
      log_tag_d  = in_tag;
      log_synd_d = in_synd;
    end else if (log_clr) begin
      log_vld_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_word_q  <= '0;
      // NOTE: the two FIFO entries are reset because the head drives out_*
      // directly and those must read zero after reset.
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      cnt_sgl_q  <= '0;
      cnt_dbl_q  <= '0;
      log_vld_q  <= 1'b0;
      log_tag_q  <= '0;
      log_synd_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_word_q  <= s1_word_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      cnt_sgl_q  <= cnt_sgl_d;
      cnt_dbl_q  <= cnt_dbl_d;
      log_vld_q  <= log_vld_d;
      log_tag_q  <= log_tag_d;
      log_synd_q <= log_synd_d;
    end
  end

endmodule

// File: tb/tb_dected_correct_stage.sv
// ---------------------------------------------------------------------------
// tb_dected_correct_stage
//   Self-checking bench for dected_correct_stage (CNT_W=2 so saturation is
//   reachable). A behavioural model classifies each accepted word from the
//   rules (syndrome zero / location popcount one / otherwise) and keeps an
//   ordered queue of expected outputs plus counter and log state.
// ---------------------------------------------------------------------------
module tb_dected_correct_stage;

  localparam int DATA_W = 32;
  localparam int SYND_W = 7;
  localparam int TAG_W  = 8;
  localparam int CNT_W  = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SYND_W-1:0] in_synd;
  logic [DATA_W-1:0] in_loc;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        out_stat;
  logic [CNT_W-1:0]  cnt_sgl;
  logic [CNT_W-1:0]  cnt_dbl;
  logic              clr_cnt;
  logic              log_vld;
  logic [TAG_W-1:0]  log_tag;
  logic [SYND_W-1:0] log_synd;
  logic              log_clr;

  dected_correct_stage #(
    .DATA_W(DATA_W), .SYND_W(SYND_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_synd(in_synd), .in_loc(in_loc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_stat(out_stat),
    .cnt_sgl(cnt_sgl), .cnt_dbl(cnt_dbl), .clr_cnt(clr_cnt),
    .log_vld(log_vld), .log_tag(log_tag), .log_synd(log_synd), .log_clr(log_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        stat;
  } exp_t;

  exp_t              exp_q[$];
  int                m_sgl, m_dbl;
  logic              m_log_vld;
  logic [TAG_W-1:0]  m_log_tag;
  logic [SYND_W-1:0] m_log_synd;
  logic              stall_prev;
  exp_t              prev_out;
  int                n_chk  = 0;
  int                n_fail = 0;

  function automatic exp_t model(logic [DATA_W-1:0] d, logic [SYND_W-1:0] s,
                                 logic [DATA_W-1:0] l, logic [TAG_W-1:0] t);
    exp_t e;
    e.tag = t;
    if (s == 0) begin
      e.stat = 2'b00; e.data = d;
    end else if ($countones(l) == 1) begin
      e.stat = 2'b01; e.data = d ^ l;
    end else begin
      e.stat = 2'b10; e.data = d;
    end
    return e;
  endfunction

  // One clock with scoreboard bookkeeping. Inputs are set #1 after an edge,
  // so everything sampled here is stable before the coming edge.
  task automatic cycle();
    bit   acc, pop;
    exp_t e, got;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    // Accept only while at most one word is in flight.
    n_chk++;
    if (in_ready !== (exp_q.size() <= 1)) begin
      n_fail++;
      $display("FAIL in_ready_occupancy: got %b want %b (in flight %0d)", in_ready, exp_q.size() <= 1, exp_q.size());
    end
    if (stall_prev) begin
      got.data = out_data; got.tag = out_tag; got.stat = out_stat;
      n_chk++;
      if (!out_valid || got != prev_out) begin
        n_fail++;
        $display("FAIL out_hold: got v=%b %h/%h/%b want v=1 %h/%h/%b", out_valid, out_data, out_tag, out_stat,
                 prev_out.data, prev_out.tag, prev_out.stat);
      end
    end
    if (pop) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %h/%h/%b want no word", out_data, out_tag, out_stat);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_tag !== e.tag || out_stat !== e.stat) begin
          n_fail++;
          $display("FAIL out_word: got %h/%h/%b want %h/%h/%b", out_data, out_tag, out_stat, e.data, e.tag, e.stat);
        end
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_out.data = out_data; prev_out.tag = out_tag; prev_out.stat = out_stat;
    if (acc) begin
      e = model(in_data, in_synd, in_loc, in_tag);
      exp_q.push_back(e);
    end
    if (clr_cnt) begin
      m_sgl = 0; m_dbl = 0;
    end else if (acc) begin
      if (e.stat == 2'b01 && m_sgl < CNT_SAT) m_sgl++;
      if (e.stat == 2'b10 && m_dbl < CNT_SAT) m_dbl++;
    end
    if (acc && e.stat == 2'b10 && (!m_log_vld || log_clr)) begin
      m_log_vld = 1'b1; m_log_tag = in_tag; m_log_synd = in_synd;
    end else if (log_clr) begin
      m_log_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (cnt_sgl !== CNT_W'(m_sgl) || cnt_dbl !== CNT_W'(m_dbl)) begin
      n_fail++;
      $display("FAIL counters: got sgl=%0d dbl=%0d want sgl=%0d dbl=%0d", cnt_sgl, cnt_dbl, m_sgl, m_dbl);
    end
    n_chk++;
    if (log_vld !== m_log_vld || (m_log_vld && (log_tag !== m_log_tag || log_synd !== m_log_synd))) begin
      n_fail++;
      $display("FAIL log: got vld=%b tag=%h synd=%h want vld=%b tag=%h synd=%h", log_vld, log_tag, log_synd,
               m_log_vld, m_log_tag, m_log_synd);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; log_clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_sgl = 0; m_dbl = 0;
    m_log_vld = 1'b0; m_log_tag = '0; m_log_synd = '0;
    stall_prev = 1'b0;
  endtask

  task automatic send_word(logic [DATA_W-1:0] d, logic [SYND_W-1:0] s,
                           logic [DATA_W-1:0] l, logic [TAG_W-1:0] t);
    bit acc;
    bit done = 0;
    in_data = d; in_synd = s; in_loc = l; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      acc = in_ready;
      cycle();
      done = acc;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got no accept want accept within 50 cycles");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || out_stat !== 2'b00 ||
        cnt_sgl !== '0 || cnt_dbl !== '0 || log_vld !== 1'b0 || log_tag !== '0 ||
        log_synd !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b od=%h ot=%h os=%b cs=%0d cd=%0d lv=%b lt=%h ls=%h ir=%b want all zero, in_ready=1",
               out_valid, out_data, out_tag, out_stat, cnt_sgl, cnt_dbl, log_vld, log_tag, log_synd, in_ready);
    end
  endtask

  task automatic test_clean();
    out_ready = 1'b1;
    in_data = 32'hDEADBEEF; in_synd = '0; in_loc = 32'h1; in_tag = 8'hA5; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_latency1: got out_valid=%b want 0", out_valid);
    end
    cycle();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_stat !== 2'b00) begin
      n_fail++;
      $display("FAIL clean_latency2: got v=%b d=%h s=%b want v=1 d=deadbeef s=00", out_valid, out_data, out_stat);
    end
    drain();
  endtask

  task automatic test_single();
    send_word(32'h00000001, 7'd97, 32'h00000001, 8'h01);
    cycle();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'h0 || out_stat !== 2'b01 || cnt_sgl !== 2'd1) begin
      n_fail++;
      $display("FAIL single: got v=%b d=%h s=%b cnt=%0d want v=1 d=00000000 s=01 cnt=1", out_valid, out_data, out_stat, cnt_sgl);
    end
    drain();
  endtask

  task automatic test_double();
    send_word(32'h12345678, 7'h7F, 32'h0000000F, 8'h3C);
    n_chk++;
    if (cnt_dbl !== 2'd1 || log_vld !== 1'b1 || log_tag !== 8'h3C || log_synd !== 7'h7F) begin
      n_fail++;
      $display("FAIL double_log: got cnt=%0d lv=%b lt=%h ls=%h want cnt=1 lv=1 lt=3c ls=7f", cnt_dbl, log_vld, log_tag, log_synd);
    end
    cycle();
    n_chk++;
    if (out_data !== 32'h12345678 || out_stat !== 2'b10) begin
      n_fail++;
      $display("FAIL double_data: got d=%h s=%b want d=12345678 s=10", out_data, out_stat);
    end
    send_word(32'hCAFEF00D, 7'h15, 32'h0, 8'h11);
    n_chk++;
    if (log_tag !== 8'h3C || cnt_dbl !== 2'd2) begin
      n_fail++;
      $display("FAIL double_sticky: got lt=%h cnt=%0d want lt=3c cnt=2", log_tag, cnt_dbl);
    end
    log_clr = 1'b1;
    send_word(32'h0, 7'h2A, 32'h00000300, 8'h22);
    log_clr = 1'b0;
    n_chk++;
    if (log_vld !== 1'b1 || log_tag !== 8'h22 || log_synd !== 7'h2A) begin
      n_fail++;
      $display("FAIL log_clr_with_event: got lv=%b lt=%h ls=%h want lv=1 lt=22 ls=2a", log_vld, log_tag, log_synd);
    end
    log_clr = 1'b1;
    cycle();
    log_clr = 1'b0;
    n_chk++;
    if (log_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL log_clr: got lv=%b want 0", log_vld);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int idx = 0;
    bit acc;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_data = 32'h1000 + idx; in_synd = '0; in_loc = '0; in_tag = 8'(idx); in_valid = 1'b1;
      acc = in_ready;
      cycle();
      if (acc) begin n_acc++; idx++; end
    end
    n_chk++;
    if (n_acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: got acc=%0d ir=%b ov=%b want acc=2 ir=0 ov=1", n_acc, in_ready, out_valid);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_rate: got out_valid=0 at drain cycle %0d want 1", c);
      end
      acc = in_ready;
      cycle();
      if (acc) idx++;
    end
    while (idx < 4) begin
      send_word(32'h1000 + idx, '0, '0, 8'(idx));
      idx++;
    end
    drain();
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_word($urandom, 7'd5, 32'h1 << i, 8'(i));
    n_chk++;
    if (cnt_sgl !== 2'd3) begin
      n_fail++;
      $display("FAIL sat: got cnt_sgl=%0d want 3", cnt_sgl);
    end
    clr_cnt = 1'b1;
    send_word(32'h0, 7'd9, 32'h80000000, 8'h77);
    clr_cnt = 1'b0;
    n_chk++;
    if (cnt_sgl !== 2'd0) begin
      n_fail++;
      $display("FAIL clr_priority: got cnt_sgl=%0d want 0", cnt_sgl);
    end
    drain();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] loc;
    bit acc;
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid && $urandom_range(3) != 0) begin
        case ($urandom_range(3))
          0: loc = 32'h1 << $urandom_range(31);
          1: loc = '0;
          2: loc = 32'h0000000F;
          default: loc = $urandom;
        endcase
        in_data = $urandom; in_loc = loc; in_tag = 8'($urandom);
        in_synd = ($urandom_range(3) == 0) ? '0 : 7'($urandom_range(127, 1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      clr_cnt = ($urandom_range(40) == 0);
      log_clr = ($urandom_range(20) == 0);
      acc = in_valid && in_ready;
      cycle();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; clr_cnt = 1'b0; log_clr = 1'b0;
    drain();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    send_word(32'h0000FFFF, 7'd3, 32'h00000100, 8'h5A);
    send_word(32'h0F0F0F0F, 7'd4, 32'h00000003, 8'h6B);
    cycle();
    n_chk++;
    if (out_valid !== 1'b1 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL mid_prefill: got ov=%b words=%0d want ov=1 words=2", out_valid, exp_q.size());
    end
    do_reset();
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || out_stat !== 2'b00 ||
        cnt_sgl !== '0 || cnt_dbl !== '0 || log_vld !== 1'b0 || log_tag !== '0 ||
        log_synd !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got ov=%b od=%h ot=%h os=%b cs=%0d cd=%0d lv=%b lt=%h ls=%h ir=%b want all zero, in_ready=1",
               out_valid, out_data, out_tag, out_stat, cnt_sgl, cnt_dbl, log_vld, log_tag, log_synd, in_ready);
    end
    out_ready = 1'b1;
    send_word(32'hA5A5A5A5, '0, '0, 8'h99);
    drain();
    cycle();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_stale: got out_valid=1 want 0 after drain");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; log_clr = 1'b0;
    in_data = '0; in_synd = '0; in_loc = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
